// File: rtl/game_pkg.sv
// Shared types and codes for the Tom & Jerry round flow: FSM states,
// latched round results and the gameover_in encoding used by is_gameover.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_COUNTDOWN = 2'b01,
    ST_PLAY      = 2'b10,
    ST_OVER      = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_TOM     = 2'b01,
    RES_JERRY   = 2'b10,
    RES_TIMEOUT = 2'b11
  } result_t;

  localparam logic [1:0] GO_NONE  = 2'b00;
  localparam logic [1:0] GO_TOM   = 2'b01;
  localparam logic [1:0] GO_JERRY = 2'b10;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Control bundle between the frame/key/gameover sources and the round
// sequencer. There is no valid/ready handshake: inputs are levels sampled
// every clock, and outputs are registered levels plus the one-cycle
// round_reset pulse.
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic        vsync;
  logic        reset_key;
  logic [1:0]  gameover_in;
  game_state_t state;
  logic        move_en;
  logic        round_reset;
  logic [1:0]  countdown;
  logic [6:0]  timer_sec;
  result_t     result;

  modport master (
    output vsync, reset_key, gameover_in,
    input  state, move_en, round_reset, countdown, timer_sec, result
  );

  modport slave (
    input  vsync, reset_key, gameover_in,
    output state, move_en, round_reset, countdown, timer_sec, result
  );
endinterface

// File: rtl/frame_sec_tick.sv
// vsync rising-edge detector and frame-to-second divider.
// clear restarts the divider so each state starts on a whole second.
module frame_sec_tick #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic clear,
  output logic frame_tick,
  output logic sec_tick
);
  localparam int CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_SEC - 1);

  logic             vsync_q;
  logic [CNT_W-1:0] frame_cnt;

  assign frame_tick = vsync & ~vsync_q;
  assign sec_tick   = frame_tick && (frame_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vsync_q <= vsync;
      // clear wins over a coincident frame tick: the new state starts at zero.
      if (clear) begin
        frame_cnt <= '0;
      end else if (frame_tick) begin
        if (frame_cnt == LAST) frame_cnt <= '0;
        else                   frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/game_flow_ctrl.sv
// Round sequencer: IDLE -> COUNTDOWN -> PLAY -> OVER, driving move enable,
// the round_reset pulse, the countdown digit, round timer and result.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC   = 60,
  parameter int COUNTDOWN_SECS   = 3,
  parameter int ROUND_SECONDS    = 99,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input logic              clk,
  input logic              rst,
  game_flow_ctrl_if.slave  bus
);
  localparam int HOLD_W = $clog2(OVER_HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD_FRAMES);
  localparam logic [6:0]        ROUND_T  = 7'(ROUND_SECONDS);
  localparam logic [1:0]        CD_START = 2'(COUNTDOWN_SECS);

  logic frame_tick, sec_tick, key_q, key_rise;
  logic enter, restart;

  game_state_t       state_q, state_d;
  result_t           result_q, result_d;
  logic [1:0]        countdown_q, countdown_d;
  logic [6:0]        timer_q, timer_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              move_en_q, move_en_d;
  logic              round_reset_q, round_reset_d;

  assign key_rise = bus.reset_key & ~key_q;

  frame_sec_tick #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .vsync      (bus.vsync),
    .clear      (enter),
    .frame_tick (frame_tick),
    .sec_tick   (sec_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      result_q      <= RES_NONE;
      countdown_q   <= 2'd0;
      timer_q       <= ROUND_T;
      hold_q        <= '0;
      move_en_q     <= 1'b0;
      round_reset_q <= 1'b0;
      key_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      countdown_q   <= countdown_d;
      timer_q       <= timer_d;
      hold_q        <= hold_d;
      move_en_q     <= move_en_d;
      round_reset_q <= round_reset_d;
      key_q         <= bus.reset_key;
    end
  end

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    countdown_d   = countdown_q;
    timer_d       = timer_q;
    hold_d        = hold_q;
    round_reset_d = 1'b0;
    enter         = 1'b0;
    restart       = 1'b0;

    unique case (state_q)
      ST_IDLE: restart = key_rise;
      ST_COUNTDOWN: begin
        if (key_rise) begin
          restart = 1'b1;
        end else if (sec_tick) begin
          if (countdown_q == 2'd1) begin
            state_d     = ST_PLAY;
            countdown_d = 2'd0;
            timer_d     = ROUND_T;
            enter       = 1'b1;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      ST_PLAY: begin
        // A real gameover beats a coincident timer expiry, so the timer keeps 1.
        if (key_rise) begin
          restart = 1'b1;
        end else if (bus.gameover_in != GO_NONE) begin
          state_d  = ST_OVER;
          result_d = result_t'(bus.gameover_in);
          enter    = 1'b1;
        end else if (sec_tick) begin
          if (timer_q == 7'd1) begin
            state_d  = ST_OVER;
            timer_d  = 7'd0;
            result_d = RES_TIMEOUT;
            enter    = 1'b1;
          end else if (timer_q != 7'd0) begin
            timer_d = timer_q - 7'd1;
          end
        end
      end
      ST_OVER: begin
        if (frame_tick && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (key_rise && hold_q == HOLD_MAX)   restart = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d       = ST_COUNTDOWN;
      countdown_d   = CD_START;
      timer_d       = ROUND_T;
      result_d      = RES_NONE;
      round_reset_d = 1'b1;
      enter         = 1'b1;
    end
    if (enter) hold_d = '0;

    move_en_d = (state_d == ST_PLAY);
  end

  assign bus.state       = state_q;
  assign bus.result      = result_q;
  assign bus.countdown   = countdown_q;
  assign bus.timer_sec   = timer_q;
  assign bus.move_en     = move_en_q;
  assign bus.round_reset = round_reset_q;
endmodule
